// File: rtl/ap_ctrl_pkg.sv
// Shared types and default constants for the ap_ctrl_hs/ap_ctrl_chain sequencer.
package ap_ctrl_pkg;

    localparam int DEF_CNT_W       = 16;
    localparam int DEF_TIMEOUT_CYC = 1000000;

    // Run-level sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // ap_continue hold-off phases: waiting for ap_done, counting the
    // hold-off, or granting ap_continue until the retirement cycle
    typedef enum logic [1:0] {
        CG_WAIT = 2'd0,
        CG_HOLD = 2'd1,
        CG_OPEN = 2'd2
    } cg_phase_t;

endpackage

// File: rtl/ap_continue_gen.sv
// ap_continue generator: holds ap_continue low for cont_delay cycles after
// ap_done is first seen, then grants it until the transaction retires.
module ap_continue_gen
    import ap_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       active,
    input  logic [7:0] cont_delay,
    input  logic       ap_done,
    output logic       ap_continue
);

    cg_phase_t  phase, phase_nxt;
    logic [7:0] rem, rem_nxt;

    // Phase and remaining hold-off count
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase <= CG_WAIT;
            rem   <= 8'd0;
        end else begin
            phase <= phase_nxt;
            rem   <= rem_nxt;
        end
    end

    // Hold-off sequencing; the cycle ap_done first rises counts as the
    // first low cycle, so rem is loaded with cont_delay-1
    always_comb begin
        phase_nxt = phase;
        rem_nxt   = rem;
        if (!active) begin
            phase_nxt = CG_WAIT;
        end else begin
            case (phase)
                CG_WAIT: begin
                    if (ap_done && cont_delay != 8'd0) begin
                        if (cont_delay == 8'd1) begin
                            phase_nxt = CG_OPEN;
                        end else begin
                            phase_nxt = CG_HOLD;
                            rem_nxt   = cont_delay - 8'd1;
                        end
                    end
                end
                CG_HOLD: begin
                    if (rem == 8'd1) phase_nxt = CG_OPEN;
                    else             rem_nxt   = rem - 8'd1;
                end
                CG_OPEN: begin
                    // ap_continue is high here, so ap_done means retirement
                    if (ap_done) phase_nxt = CG_WAIT;
                end
                default: phase_nxt = CG_WAIT;
            endcase
        end
    end

    // Outside a run, or with zero hold-off, behave like plain ap_ctrl_hs
    always_comb begin
        ap_continue = !active || (cont_delay == 8'd0) || (phase == CG_OPEN);
    end

endmodule

// File: rtl/ap_ctrl_sequencer.sv
// Run sequencer for an HLS block-level handshake: issues num_trans starts,
// retires the matching dones, and reports counts, cycle time and errors.
module ap_ctrl_sequencer
    import ap_ctrl_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_cmd,
    input  logic [CNT_W-1:0] num_trans,
    input  logic [7:0]       cont_delay,
    output logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    output logic             ap_continue,
    output logic             busy,
    output logic             finish,
    output logic             err,
    output logic [CNT_W-1:0] issued_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [31:0]      run_cycles
);

    localparam logic [31:0] WD_LAST = 32'(TIMEOUT_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] num_q;
    logic [7:0]       delay_q;
    logic [31:0]      wd;

    logic accept, issue_hs, retire, progress;
    logic issue_last, done_last, timeout, violation;

    assign accept     = start_cmd && (state == IDLE || state == FINISH);
    assign issue_hs   = ap_start && ap_ready;
    assign retire     = busy && ap_done && ap_continue;
    assign progress   = issue_hs || retire;
    assign issue_last = issue_hs && (issued_cnt + CNT_W'(1) == num_q);
    assign done_last  = (done_cnt == num_q) || (retire && (done_cnt + CNT_W'(1) == num_q));
    assign timeout    = busy && !progress && (wd == WD_LAST);
    // Retiring with nothing outstanding, or a ready nobody asked for
    assign violation  = busy && ((retire && done_cnt == issued_cnt) || (ap_ready && !ap_start));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FINISH: begin
                if (accept) state_nxt = (num_trans == '0) ? FINISH : ISSUE;
            end
            ISSUE: begin
                if (timeout)         state_nxt = FINISH;
                else if (issue_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (timeout || done_last) state_nxt = FINISH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        ap_start = (state == ISSUE);
        busy     = (state == ISSUE) || (state == DRAIN);
        finish   = (state == FINISH);
    end

    // Run parameters, counters, watchdog and sticky error
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            num_q      <= '0;
            delay_q    <= 8'd0;
            issued_cnt <= '0;
            done_cnt   <= '0;
            err        <= 1'b0;
            run_cycles <= 32'd0;
            wd         <= 32'd0;
        end else if (accept) begin
            num_q      <= num_trans;
            delay_q    <= cont_delay;
            issued_cnt <= '0;
            done_cnt   <= '0;
            err        <= 1'b0;
            run_cycles <= 32'd0;
            wd         <= 32'd0;
        end else if (busy) begin
            if (issue_hs && issued_cnt != num_q) issued_cnt <= issued_cnt + CNT_W'(1);
            if (retire && done_cnt != num_q)     done_cnt   <= done_cnt + CNT_W'(1);
            if (run_cycles != '1)                run_cycles <= run_cycles + 32'd1;
            wd <= progress ? 32'd0 : wd + 32'd1;
            if (violation || timeout) err <= 1'b1;
        end
    end

    ap_continue_gen u_cont (
        .clock       (clock),
        .reset       (reset),
        .active      (busy),
        .cont_delay  (delay_q),
        .ap_done     (ap_done),
        .ap_continue (ap_continue)
    );

endmodule

// File: tb/tb_ap_ctrl_sequencer.sv
// Directed bench for ap_ctrl_sequencer with a short watchdog.
module tb_ap_ctrl_sequencer;

    localparam int CNT_W = 16;

    logic             clock = 1'b0;
    logic             reset;
    logic             start_cmd;
    logic [CNT_W-1:0] num_trans;
    logic [7:0]       cont_delay;
    logic             ap_start;
    logic             ap_ready;
    logic             ap_done;
    logic             ap_continue;
    logic             busy;
    logic             finish;
    logic             err;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] done_cnt;
    logic [31:0]      run_cycles;

    int checks = 0;
    int errors = 0;

    ap_ctrl_sequencer #(.CNT_W(CNT_W), .TIMEOUT_CYC(50)) dut (
        .clock       (clock),
        .reset       (reset),
        .start_cmd   (start_cmd),
        .num_trans   (num_trans),
        .cont_delay  (cont_delay),
        .ap_start    (ap_start),
        .ap_ready    (ap_ready),
        .ap_done     (ap_done),
        .ap_continue (ap_continue),
        .busy        (busy),
        .finish      (finish),
        .err         (err),
        .issued_cnt  (issued_cnt),
        .done_cnt    (done_cnt),
        .run_cycles  (run_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic launch(input logic [CNT_W-1:0] n, input logic [7:0] d);
        start_cmd  = 1'b1;
        num_trans  = n;
        cont_delay = d;
        tick(1);
        start_cmd  = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " ap_start"},    32'(ap_start),    32'd0);
        check({tag, " ap_continue"}, 32'(ap_continue), 32'd1);
        check({tag, " busy"},        32'(busy),        32'd0);
        check({tag, " finish"},      32'(finish),      32'd0);
        check({tag, " err"},         32'(err),         32'd0);
        check({tag, " issued"},      32'(issued_cnt),  32'd0);
        check({tag, " done"},        32'(done_cnt),    32'd0);
        check({tag, " run_cycles"},  run_cycles,       32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        start_cmd  = 1'b0;
        num_trans  = '0;
        cont_delay = 8'd0;
        ap_ready   = 1'b0;
        ap_done    = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_vals("rst");
        tick(2);
        #2 reset = 1'b1;
        tick(1);

        // Three transactions, no hold-off: ready 2 cycles in, done 5 after accept
        launch(16'd3, 8'd0);
        check("A busy", 32'(busy), 32'd1);
        check("A ap_start", 32'(ap_start), 32'd1);
        check("A cont hs", 32'(ap_continue), 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick(2);
            ap_ready = 1'b1;
            tick(1);
            ap_ready = 1'b0;
            check("A issued", 32'(issued_cnt), 32'(k + 1));
            check("A ap_start after hs", 32'(ap_start), (k == 2) ? 32'd0 : 32'd1);
            tick(4);
            ap_done = 1'b1;
            tick(1);
            ap_done = 1'b0;
            check("A done", 32'(done_cnt), 32'(k + 1));
        end
        check("A finish", 32'(finish), 32'd1);
        check("A busy end", 32'(busy), 32'd0);
        check("A err", 32'(err), 32'd0);
        check("A run_cycles", run_cycles, 32'd24);
        check("A cont finish", 32'(ap_continue), 32'd1);

        // Zero transactions, launched from FINISH
        launch(16'd0, 8'd0);
        check("B finish", 32'(finish), 32'd1);
        check("B ap_start", 32'(ap_start), 32'd0);
        check("B issued", 32'(issued_cnt), 32'd0);
        check("B done", 32'(done_cnt), 32'd0);
        check("B run_cycles", run_cycles, 32'd0);
        tick(1);
        check("B ap_start later", 32'(ap_start), 32'd0);

        // Hold-off of 4 cycles on each of two dones
        launch(16'd2, 8'd4);
        check("C cont wait", 32'(ap_continue), 32'd0);
        ap_ready = 1'b1;
        tick(2);
        ap_ready = 1'b0;
        check("C issued", 32'(issued_cnt), 32'd2);
        check("C ap_start drain", 32'(ap_start), 32'd0);
        for (int t = 0; t < 2; t++) begin
            ap_done = 1'b1;
            check("C cont t0", 32'(ap_continue), 32'd0);
            for (int c = 1; c < 4; c++) begin
                tick(1);
                check("C cont hold", 32'(ap_continue), 32'd0);
            end
            tick(1);
            check("C cont open", 32'(ap_continue), 32'd1);
            check("C done before", 32'(done_cnt), 32'(t));
            tick(1);
            ap_done = 1'b0;
            check("C done after", 32'(done_cnt), 32'(t + 1));
            check("C cont relow", 32'(ap_continue), (t == 0) ? 32'd0 : 32'd1);
        end
        check("C finish", 32'(finish), 32'd1);
        check("C err", 32'(err), 32'd0);

        // ap_ready and ap_done in the same cycle with one outstanding
        launch(16'd2, 8'd0);
        ap_ready = 1'b1;
        tick(1);
        ap_done = 1'b1;
        tick(1);
        ap_ready = 1'b0;
        check("D1 issued", 32'(issued_cnt), 32'd2);
        check("D1 done", 32'(done_cnt), 32'd1);
        check("D1 err", 32'(err), 32'd0);
        tick(1);
        ap_done = 1'b0;
        check("D1 finish", 32'(finish), 32'd1);
        check("D1 done end", 32'(done_cnt), 32'd2);
        check("D1 err end", 32'(err), 32'd0);

        // Spurious ap_done with nothing outstanding: counted, flagged, run continues
        launch(16'd2, 8'd0);
        ap_done = 1'b1;
        tick(1);
        ap_done = 1'b0;
        check("D2 err", 32'(err), 32'd1);
        check("D2 done", 32'(done_cnt), 32'd1);
        check("D2 busy", 32'(busy), 32'd1);
        ap_ready = 1'b1;
        tick(2);
        ap_ready = 1'b0;
        check("D2 issued", 32'(issued_cnt), 32'd2);
        ap_done = 1'b1;
        tick(1);
        ap_done = 1'b0;
        check("D2 finish", 32'(finish), 32'd1);
        check("D2 err held", 32'(err), 32'd1);

        // Watchdog: DUT never ready
        launch(16'd5, 8'd0);
        tick(49);
        check("E finish early", 32'(finish), 32'd0);
        check("E err early", 32'(err), 32'd0);
        check("E ap_start early", 32'(ap_start), 32'd1);
        tick(1);
        check("E finish", 32'(finish), 32'd1);
        check("E err", 32'(err), 32'd1);
        check("E ap_start", 32'(ap_start), 32'd0);
        check("E run_cycles", run_cycles, 32'd50);
        tick(2);
        check("E ap_start later", 32'(ap_start), 32'd0);

        // Reset in DRAIN with one done, then a clean run
        launch(16'd2, 8'd0);
        ap_ready = 1'b1;
        tick(2);
        ap_ready = 1'b0;
        ap_done  = 1'b1;
        tick(1);
        ap_done  = 1'b0;
        check("F done pre", 32'(done_cnt), 32'd1);
        check("F busy pre", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1 check_reset_vals("F rst");
        reset = 1'b1;
        tick(1);
        check("F idle finish", 32'(finish), 32'd0);
        launch(16'd1, 8'd0);
        ap_ready = 1'b1;
        tick(1);
        ap_ready = 1'b0;
        ap_done  = 1'b1;
        tick(1);
        ap_done  = 1'b0;
        check("F finish", 32'(finish), 32'd1);
        check("F err", 32'(err), 32'd0);
        check("F issued", 32'(issued_cnt), 32'd1);
        check("F done", 32'(done_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
